sgf_addsub_norm: RTL
====================

Name: sgf_addsub_norm

Overview:
- Stage directly downstream of the exponent-difference / significand-alignment stage.
- Consumes the aligned smallest significand (W_Sgf+3 bits: hidden bit, fraction, 2 guard bits) and adds it to, or subtracts it from, the largest operand's significand.
- Renormalizes the result against the largest exponent using a multi-cycle shift FSM.
- Produces the pre-rounding significand, exponent and status flags for the rounding phase.

Parameters:
W_Exp, 8, exponent width (11 for double)
W_Sgf, 23, stored fraction width (52 for double)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset
start  in  1  one-cycle request; operands sampled when start=1 in IDLE
op_mode  in  1  0=add, 1=subtract (effective operation)
exp_M  in  W_Exp  largest exponent
sgfM  in  W_Sgf  fraction of largest operand
sgfm_n  in  W_Sgf+3  aligned smallest significand from alignment stage
busy  out  1  high in ADD and NORM states
done  out  1  one-cycle pulse in DONE state
sgf_r  out  W_Sgf+3  normalized significand, hidden bit at [W_Sgf+2]
exp_r  out  W_Exp  adjusted exponent
zero_flag  out  1  result is exactly zero
sign_inv  out  1  subtraction borrowed; result sign is opposite to the largest operand
ovf  out  1  exponent overflow
unf  out  1  exponent underflow / denormal flush

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE; all outputs and internal registers are 0. Asserting reset mid-operation aborts the operation; no done pulse is issued.
- States: IDLE, ADD, NORM, DONE.
- IDLE:
  - start=1 captures op_mode, exp_M, {1'b1,sgfM,2'b00} and sgfm_n; next state ADD.
  - start=0: remain in IDLE.
- ADD:
  - sum (W_Sgf+4 bits) = {0,A} + {0,B} or {0,A} - {0,B}.
  - If subtraction borrows: sum is replaced by its two's complement and sign_inv is set.
  - Next state NORM; working exponent = exp_M.
- NORM: evaluated each cycle, in this priority order:
  1. sum==0: zero_flag=1, exp=0, sgf=0; go to DONE.
  2. sum[W_Sgf+3]=1 (carry out):
     - Shift right by 1; new LSB = sum[1] OR sum[0] (sticky).
     - Exponent +1; if the result is all-ones, ovf=1.
     - Go to DONE.
  3. sum[W_Sgf+2]=1: already normalized; go to DONE.
  4. Exponent == 0: unf=1; go to DONE with the current sgf, exp=0.
  5. Otherwise: shift left by 1, exponent -1; stay in NORM.
- DONE:
  - sgf_r, exp_r and flags are registered on entry; done=1 for exactly one cycle; next state IDLE.
  - Outputs hold their values until the next DONE. zero_flag, sign_inv, ovf and unf are cleared when a new start is captured.
- Latency: start sampled at edge N → done high in cycle N+3, plus one cycle per left shift. Maximum is N+3+W_Sgf+2.
- start while busy or in DONE is ignored; no queueing.
- sgf_r = sum[W_Sgf+2:0] after normalization.

Optional Feature:
- SGF_NORM_FAST_EN defined:
  - NORM uses a combinational leading-zero counter (lzc) on sum[W_Sgf+2:0].
  - Shift = min(lzc, exponent), applied in one cycle.
  - unf=1 if lzc > exponent.
  - NORM therefore always takes one cycle, and done arrives at N+3 in every case.
- Not defined: one-bit-per-cycle left shift as described in Behaviour.
- Final results and flags are identical in both modes; only latency differs.

Test Plan (W_Exp=8, W_Sgf=23):
- Add carry: exp_M=0x80, sgfM=0, sgfm_n=0x2000000, op_mode=0 → sgf_r=0x2000000, exp_r=0x81, all flags 0, done at N+3.
- Exact cancel: same operands, op_mode=1 → zero_flag=1, sgf_r=0, exp_r=0, done at N+3.
- Cancellation shift: exp_M=0x80, sgfM=0, sgfm_n=0x1C00000, op_mode=1 → sgf_r=0x2000000, exp_r=0x7D, done at N+6 (N+3 with SGF_NORM_FAST_EN).
- Overflow: exp_M=0xFE, sgfM=0, sgfm_n=0x2000000, op_mode=0 → exp_r=0xFF, ovf=1.
- Underflow: exp_M=0x02, sgfM=0, sgfm_n=0x1C00000, op_mode=1 → unf=1, exp_r=0, sgf_r=0x1000000.
- Control:
  - start re-pulsed during NORM → ignored; the first result is unchanged.
  - rst=0 during NORM → busy=0, all outputs 0 immediately, no done pulse.
  - A following start completes normally.

Source files
------------

// File: rtl/sgf_addsub_norm.sv
// Significand add/subtract followed by renormalization against the largest exponent.
// Optional macro SGF_NORM_FAST_EN: single-cycle leading-zero normalization instead of 1 bit/cycle.
module sgf_addsub_norm #(
  parameter int W_Exp = 8,
  parameter int W_Sgf = 23
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             op_mode,
  input  logic [W_Exp-1:0] exp_M,
  input  logic [W_Sgf-1:0] sgfM,
  input  logic [W_Sgf+2:0] sgfm_n,
  output logic             busy,
  output logic             done,
  output logic [W_Sgf+2:0] sgf_r,
  output logic [W_Exp-1:0] exp_r,
  output logic             zero_flag,
  output logic             sign_inv,
  output logic             ovf,
  output logic             unf
);

  localparam int SW  = W_Sgf + 4;
  localparam int LZW = $clog2(SW) + 1;

  typedef enum logic [1:0] {IDLE, ADD, NORM, DONE} state_t;

  state_t           state_q, state_d;
  logic             op_q, op_d;
  logic [SW-2:0]    a_q, a_d, b_q, b_d;
  logic [SW-1:0]    sum_q, sum_d;
  logic [W_Exp-1:0] exp_q, exp_d;
  logic             sign_q, sign_d;
  logic [SW-2:0]    sgf_r_q, sgf_r_d;
  logic [W_Exp-1:0] exp_r_q, exp_r_d;
  logic             zero_q, zero_d, sinv_q, sinv_d, ovf_q, ovf_d, unf_q, unf_d;

  logic [SW-1:0]    diff;
  logic [W_Exp-1:0] exp_inc;

  // Right shift by one that keeps the two dropped-into bits alive as a sticky LSB.
  function automatic logic [SW-2:0] sticky_rshift(input logic [SW-1:0] v);
    sticky_rshift = {v[SW-1:2], v[1] | v[0]};
  endfunction

`ifdef SGF_NORM_FAST_EN
  logic [LZW-1:0] lz;

  function automatic logic [LZW-1:0] lzc(input logic [SW-2:0] v);
    lzc = LZW'(SW - 1);
    for (int i = 0; i < SW - 1; i++)
      if (v[i]) lzc = LZW'(SW - 2 - i);
  endfunction
`endif

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    exp_d   = exp_q;
    sign_d  = sign_q;
    sgf_r_d = sgf_r_q;
    exp_r_d = exp_r_q;
    zero_d  = zero_q;
    sinv_d  = sinv_q;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    diff    = {1'b0, a_q} - {1'b0, b_q};
    exp_inc = exp_q + W_Exp'(1);
`ifdef SGF_NORM_FAST_EN
    lz      = lzc(sum_q[SW-2:0]);
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          op_d    = op_mode;
          exp_d   = exp_M;
          a_d     = {1'b1, sgfM, 2'b00};
          b_d     = sgfm_n;
          sign_d  = 1'b0;
          zero_d  = 1'b0;
          sinv_d  = 1'b0;
          ovf_d   = 1'b0;
          unf_d   = 1'b0;
          state_d = ADD;
        end
      end
      ADD: begin
        if (!op_q) begin
          sum_d = {1'b0, a_q} + {1'b0, b_q};
        end else if (diff[SW-1]) begin
          // Borrow: magnitude is the two's complement, sign flips relative to the larger operand.
          sum_d  = (~diff) + SW'(1);
          sign_d = 1'b1;
        end else begin
          sum_d = diff;
        end
        state_d = NORM;
      end
      NORM: begin
        sinv_d = sign_q;
        if (sum_q == '0) begin
          zero_d  = 1'b1;
          sgf_r_d = '0;
          exp_r_d = '0;
          state_d = DONE;
        end else if (sum_q[SW-1]) begin
          sgf_r_d = sticky_rshift(sum_q);
          exp_r_d = exp_inc;
          ovf_d   = &exp_inc;
          state_d = DONE;
        end else if (sum_q[SW-2]) begin
          sgf_r_d = sum_q[SW-2:0];
          exp_r_d = exp_q;
          state_d = DONE;
`ifdef SGF_NORM_FAST_EN
        end else begin
          // Shift is capped by the exponent; anything left over is an underflow.
          if (int'(lz) > int'(exp_q)) begin
            sgf_r_d = sum_q[SW-2:0] << exp_q;
            exp_r_d = '0;
            unf_d   = 1'b1;
          end else begin
            sgf_r_d = sum_q[SW-2:0] << lz;
            exp_r_d = exp_q - W_Exp'(lz);
          end
          state_d = DONE;
        end
`else
        end else if (exp_q == '0) begin
          sgf_r_d = sum_q[SW-2:0];
          exp_r_d = '0;
          unf_d   = 1'b1;
          state_d = DONE;
        end else begin
          sum_d = sum_q << 1;
          exp_d = exp_q - W_Exp'(1);
        end
`endif
      end
      DONE: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      op_q    <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      exp_q   <= '0;
      sign_q  <= 1'b0;
      sgf_r_q <= '0;
      exp_r_q <= '0;
      zero_q  <= 1'b0;
      sinv_q  <= 1'b0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      exp_q   <= exp_d;
      sign_q  <= sign_d;
      sgf_r_q <= sgf_r_d;
      exp_r_q <= exp_r_d;
      zero_q  <= zero_d;
      sinv_q  <= sinv_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  assign busy      = (state_q == ADD) || (state_q == NORM);
  assign done      = (state_q == DONE);
  assign sgf_r     = sgf_r_q;
  assign exp_r     = exp_r_q;
  assign zero_flag = zero_q;
  assign sign_inv  = sinv_q;
  assign ovf       = ovf_q;
  assign unf       = unf_q;

endmodule
